// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_pkg
// Purpose  : Shared types and defaults for the overlapping serial pattern
//            detector (state enum, default pattern/sizes, position width
//            helper).
// Revision : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int          DEF_PAT_LEN = 4;
    localparam logic [15:0] DEF_PATTERN = 16'h000B;   // 4'b1011
    localparam int          DEF_FRAME_W = 16;
    localparam int          DEF_CNT_W   = 5;

    // Width of a frame bit index; never narrower than one bit.
    function automatic int pos_w(input int frame_w);
        return (frame_w > 1) ? $clog2(frame_w) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_hist_sr.sv
`default_nettype none
// ============================================================================
// Module   : seq_hist_sr
// Purpose  : (PAT_LEN-1)-bit history shift register plus saturating fill
//            counter. The window/full outputs describe the history an
//            incoming bit is compared against this cycle, i.e. after an
//            optional pre-clear (start of a new frame).
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            clr_pre       - clear history before this cycle's shift
//            clr_post      - clear history after this cycle's shift
//            shift_en      - shift bit_in into the history
//            bit_in        - serial data bit
//            window        - history seen by the incoming bit
//            full          - at least PAT_LEN-1 bits held in the history
// Revision : 1.0 - initial release
// ============================================================================
module seq_hist_sr #(
    parameter int PAT_LEN = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_pre,
    input  logic               clr_post,
    input  logic               shift_en,
    input  logic               bit_in,
    output logic [PAT_LEN-2:0] window,
    output logic               full
);

    localparam int                FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-2:0] hist_q;
    logic [PAT_LEN-2:0] hist_d;
    logic [PAT_LEN-2:0] hist_base;
    logic [PAT_LEN-2:0] hist_shift;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_d;
    logic [FILL_W-1:0]  fill_base;

    assign hist_base = clr_pre ? '0 : hist_q;
    assign fill_base = clr_pre ? '0 : fill_q;

    generate
        if (PAT_LEN > 2) begin : g_wide
            assign hist_shift = {hist_base[PAT_LEN-3:0], bit_in};
        end else begin : g_narrow
            assign hist_shift = bit_in;
        end
    endgenerate

    always_comb begin
        hist_d = hist_base;
        fill_d = fill_base;
        if (shift_en) begin
            hist_d = hist_shift;
            if (fill_base != FILL_MAX) begin
                fill_d = fill_base + FILL_W'(1);
            end
        end
        // Frame close: the bit above still counts, then history is dropped.
        if (clr_post) begin
            hist_d = '0;
            fill_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign window = hist_base;
    assign full   = (fill_base >= FILL_FULL);

endmodule
`default_nettype wire

// File: rtl/overlap_seq_detector.sv
`default_nettype none
// ============================================================================
// Module   : overlap_seq_detector
// Purpose  : Detects every (overlapping) occurrence of a PAT_LEN-bit pattern
//            in an MSB-first serial stream, reports each hit with its frame
//            bit index and latches a saturating per-frame hit count at end
//            of frame.
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            bit_in        - serial data (ignored when bit_valid=0)
//            bit_valid     - bit_in carries a data bit this cycle
//            frame_start   - opens a new frame (bit_valid = bit 0)
//            frame_end     - closes the frame and latches the count
//            match         - one-cycle hit pulse
//            match_pos     - frame index of the completing bit
//            match_count   - hits in the last closed frame (held)
//            count_valid   - one-cycle pulse when match_count updates
//            count_sat     - last closed frame saturated the counter
// Revision : 1.0 - initial release
// ============================================================================
module overlap_seq_detector
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
    parameter int                 FRAME_W = DEF_FRAME_W,
    parameter int                 CNT_W   = DEF_CNT_W,
    localparam int                POS_W   = pos_w(FRAME_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    input  logic             frame_end,
    output logic             match,
    output logic [POS_W-1:0] match_pos,
    output logic [CNT_W-1:0] match_count,
    output logic             count_valid,
    output logic             count_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q;
    state_t             state_d;
    logic               run;
    logic               fe_run;
    logic               close_only;
    logic               accept;
    logic               hit;
    logic [PAT_LEN-2:0] window;
    logic               full;
    logic [POS_W-1:0]   idx_q;
    logic [POS_W-1:0]   idx_d;
    logic [POS_W-1:0]   idx_base;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W-1:0]   cnt_upd;
    logic               sat_q;
    logic               sat_d;
    logic               sat_upd;
    logic               match_q;
    logic               match_d;
    logic [POS_W-1:0]   match_pos_q;
    logic [POS_W-1:0]   match_pos_d;
    logic [CNT_W-1:0]   match_count_q;
    logic [CNT_W-1:0]   match_count_d;
    logic               count_valid_q;
    logic               count_valid_d;
    logic               count_sat_q;
    logic               count_sat_d;

    assign run        = (state_q == ST_RUN);
    assign fe_run     = run & frame_end;
    // Frame closes with no new frame opening: clear after this cycle's bit.
    assign close_only = fe_run & ~frame_start;
    // A bit arriving with frame_start is bit 0 of the new frame, even from IDLE.
    assign accept     = bit_valid & (run | frame_start);

    seq_hist_sr #(
        .PAT_LEN (PAT_LEN)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .clr_pre  (frame_start),
        .clr_post (close_only),
        .shift_en (accept),
        .bit_in   (bit_in),
        .window   (window),
        .full     (full)
    );

    // window/full already reflect a frame_start clear, so a hit can never
    // coincide with frame_start; cnt_q is therefore the old frame's count.
    assign hit = accept & full & ({window, bit_in} == PATTERN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (frame_start)              state_d = ST_RUN;
            ST_RUN:  if (frame_end & ~frame_start) state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_base = frame_start ? '0 : idx_q;
        idx_d    = idx_base;
        if (close_only) begin
            idx_d = '0;
        end else if (accept) begin
            idx_d = idx_base + POS_W'(1);
        end

        cnt_upd = cnt_q;
        sat_upd = sat_q;
        if (hit) begin
            if (cnt_q == CNT_MAX) begin
                sat_upd = 1'b1;
            end else begin
                cnt_upd = cnt_q + CNT_W'(1);
            end
        end
        cnt_d = (frame_start | fe_run) ? '0   : cnt_upd;
        sat_d = (frame_start | fe_run) ? 1'b0 : sat_upd;

        match_d       = hit;
        match_pos_d   = hit ? idx_base : match_pos_q;

        match_count_d = match_count_q;
        count_sat_d   = count_sat_q;
        count_valid_d = 1'b0;
        if (fe_run) begin
            match_count_d = cnt_upd;
            count_sat_d   = sat_upd;
            count_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            sat_q         <= 1'b0;
            match_q       <= 1'b0;
            match_pos_q   <= '0;
            match_count_q <= '0;
            count_valid_q <= 1'b0;
            count_sat_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            sat_q         <= sat_d;
            match_q       <= match_d;
            match_pos_q   <= match_pos_d;
            match_count_q <= match_count_d;
            count_valid_q <= count_valid_d;
            count_sat_q   <= count_sat_d;
        end
    end

    assign match       = match_q;
    assign match_pos   = match_pos_q;
    assign match_count = match_count_q;
    assign count_valid = count_valid_q;
    assign count_sat   = count_sat_q;

endmodule
`default_nettype wire
